primegen_cached: RTL and testbench
==================================

// Module: primegen_cached
// PURPOSE
//  Parametrised successor to primegen. Emits primes in order, one per go request.
//  The sequence is 1, 2, 3, 5, 7, ...
//  Candidates are tested by trial division against an internal cache of earlier primes.
//  Divisions run sequentially.
//  Sits behind any controller that needs an ordered prime stream via a go/ready handshake.
// PARAMETERS
//  WIDTH        16  bit width of res and of all candidates (>=4)
//  CACHE_DEPTH  32  number of primes (starting at 2) held in the divisor cache (>=2)
// PORTS
//  clk      in   1             single clock; all state changes on posedge
//  rst_n    in   1             synchronous, active-low reset
//  go       in   1             request next prime; sampled on posedge
//  restart  in   1             synchronous rewind to res=1; cache contents kept
//  ready    out  1             res valid, block idle
//  error    out  1             sticky; no further primes can be produced
//  err_code out  2             0 none, 1 overflow, 2 cache exhausted
//  res      out  WIDTH         current prime
//  idx      out  WIDTH         ordinal of res (1 -> 0, 2 -> 1, 3 -> 2, ...)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - ready=1, res=1, idx=0, error=0, err_code=0.
//   - Cache count=0; any search in progress is aborted.
//  go accepted only when ready=1 and error=0; otherwise ignored.
//  After an accepted go, ready=0 from the next cycle until the result is committed.
//  restart has priority over go:
//   - next cycle res=1, idx=0, ready=1, error cleared.
//   - Cache retained; stored primes are not re-inserted.
//  FSM states: IDLE, NEXT, DIV_START, DIV_WAIT, COMMIT, ERR.
//   IDLE      go -> NEXT.
//   NEXT      res<3: cand=res+1 -> COMMIT (2 and 3 are prime by rule).
//             Otherwise cand=res+2; if it wraps past 2^WIDTH-1 -> ERR with code 1.
//             Else j=1 (first odd cached prime) -> DIV_START.
//   DIV_START If j<count and p[j]^2<=cand: launch cand mod p[j] -> DIV_WAIT.
//             If j<count and p[j]^2>cand -> COMMIT.
//             If j==count and cache not full -> COMMIT.
//             If j==count and cache full:
//               (p[count-1]+2)^2>cand -> COMMIT; else -> ERR with code 2.
//   DIV_WAIT  On rem_valid:
//               rem==0 -> cand+=2 (overflow check as in NEXT), j=1, DIV_START.
//               rem!=0 -> j++, DIV_START.
//   COMMIT    res=cand, idx++.
//             If count<CACHE_DEPTH and cand>=2: cache[count]=cand, count++.
//             ready=1 -> IDLE.
//   ERR       ready=1, error=1, res/idx hold the last good prime.
//             Leave only via rst_n or restart.
//  Arithmetic and widths:
//   - Squares computed in 2*WIDTH bits; no truncation.
//   - Overflow detected via a WIDTH+1-bit add.
//  Latency:
//   - 1->2 and 2->3 commit 2 cycles after go is accepted.
//   - Each division costs WIDTH+2 cycles.
//  res, idx and err_code are stable whenever ready=1.
// STRUCTURE
//  prime_pkg:
//   - err codes ERR_NONE/ERR_OVF/ERR_CACHE
//   - FSM state enum
//   - clog2 helper for the cache index width
//  Sub-module mod_seq #(WIDTH): restoring sequential remainder.
//   - Ports: start, a, b -> rem, rem_valid.
//   - rem_valid pulses WIDTH+1 cycles after start.
//   - Reset shares rst_n.
//  Cache is a register array, CACHE_DEPTH x WIDTH, with count register.
// TESTING
//  1 W=16 D=32: reset, 11 go pulses -> res 1,2,3,5,7,11,13,17,19,23,29,31; idx 0..11.
//  2 W=8 D=8: go until 251 -> idx=54; next go -> error=1, err_code=1, res=251.
//  3 W=8 D=4: sequence up to 79 correct; next go (cand 81) -> error=1, err_code=2, res=79.
//  4 go held high while ready=0 -> exactly one advance per accepted go; go while error=1 -> no change.
//  5 restart at res=13 with go same cycle -> res=1, idx=0, ready=1.
//    Then 3 gos -> 2,3,5; cache count unchanged at 6.
//  6 rst_n=0 mid-division (ready=0) -> next cycle ready=1, res=1, err_code=0, cache empty.

Source files
------------

// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared types and helpers for the cached prime generator
package prime_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVF   = 2'd1,
    ERR_CACHE = 2'd2
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_DIV_START,
    S_DIV_WAIT,
    S_COMMIT,
    S_ERR
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/primegen_cached_mod_seq.sv
// rtl/primegen_cached_mod_seq.sv - restoring sequential remainder a mod b
module mod_seq
  import prime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem,
  output logic             rem_valid
);

  localparam int CNW = clog2(WIDTH + 1);

  logic [WIDTH-1:0] q, r, bl;
  logic [CNW-1:0]   cnt;
  logic             busy;
  logic [WIDTH:0]   trial, diff;

  assign trial = {r, q[WIDTH-1]};
  assign diff  = trial - {1'b0, bl};
  assign rem   = r;

  // One quotient bit per cycle, then a final cycle to raise rem_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      r         <= '0;
      bl        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      rem_valid <= 1'b0;
    end else begin
      rem_valid <= 1'b0;
      if (start) begin
        q    <= a;
        r    <= '0;
        bl   <= b;
        cnt  <= CNW'(WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt != '0) begin
          q   <= {q[WIDTH-2:0], 1'b0};
          r   <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt <= cnt - CNW'(1);
        end else begin
          rem_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/primegen_cached.sv
// rtl/primegen_cached.sv - ordered prime generator using trial division against a prime cache
module primegen_cached
  import prime_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CACHE_DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             restart,
  output logic             ready,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] idx
);

  localparam int CW = clog2(CACHE_DEPTH + 1);
  localparam int AW = clog2(CACHE_DEPTH);

  state_e           state, state_n;
  err_code_e        err_r, err_n;
  logic [WIDTH-1:0] cache [CACHE_DEPTH];
  logic [CW-1:0]    count, j;
  logic [WIDTH-1:0] cand, rem, p_j, p_last;
  logic             rem_valid, div_start, j_lt, full, cache_we;
  logic [WIDTH:0]   res_p2, cand_p2, p_last_p2;
  logic [2*WIDTH-1:0] p_sq;
  logic [2*WIDTH+1:0] last_sq;

  mod_seq #(.WIDTH(WIDTH)) u_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .a        (cand),
    .b        (p_j),
    .rem      (rem),
    .rem_valid(rem_valid)
  );

  assign j_lt      = j < count;
  assign full      = count == CW'(CACHE_DEPTH);
  assign p_j       = j_lt ? cache[AW'(j)] : '0;
  assign p_last    = cache[AW'(count - CW'(1))];
  assign p_sq      = (2*WIDTH)'(p_j) * (2*WIDTH)'(p_j);
  assign p_last_p2 = {1'b0, p_last} + (WIDTH+1)'(2);
  assign last_sq   = (2*WIDTH+2)'(p_last_p2) * (2*WIDTH+2)'(p_last_p2);
  assign res_p2    = {1'b0, res} + (WIDTH+1)'(2);
  assign cand_p2   = {1'b0, cand} + (WIDTH+1)'(2);

  assign ready    = (state == S_IDLE) || (state == S_ERR);
  assign error    = state == S_ERR;
  assign err_code = err_r;

  always_comb begin
    state_n   = state;
    err_n     = ERR_NONE;
    div_start = 1'b0;
    case (state)
      S_IDLE: if (go) state_n = S_NEXT;
      S_NEXT: begin
        if (res < WIDTH'(3))  state_n = S_COMMIT;
        else if (res_p2[WIDTH]) begin
          state_n = S_ERR;
          err_n   = ERR_OVF;
        end else state_n = S_DIV_START;
      end
      S_DIV_START: begin
        if (j_lt) begin
          if (p_sq <= (2*WIDTH)'(cand)) begin
            div_start = 1'b1;
            state_n   = S_DIV_WAIT;
          end else state_n = S_COMMIT;
        end else if (!full || last_sq > (2*WIDTH+2)'(cand)) begin
          state_n = S_COMMIT;
        end else begin
          state_n = S_ERR;
          err_n   = ERR_CACHE;
        end
      end
      S_DIV_WAIT: begin
        if (rem_valid) begin
          if (rem == '0 && cand_p2[WIDTH]) begin
            state_n = S_ERR;
            err_n   = ERR_OVF;
          end else state_n = S_DIV_START;
        end
      end
      S_COMMIT: state_n = S_IDLE;
      S_ERR:    state_n = S_ERR;
      default:  state_n = S_IDLE;
    endcase
    if (restart) state_n = S_IDLE;
  end

  // A prime goes into the cache only when its ordinal is the next free slot,
  // so replaying the sequence after a restart never duplicates entries.
  assign cache_we = rst_n && !restart && (state == S_COMMIT) && !full
                    && (idx == WIDTH'(count));

  always_ff @(posedge clk) begin
    if (cache_we) cache[AW'(count)] <= cand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      err_r <= ERR_NONE;
      res   <= WIDTH'(1);
      idx   <= '0;
      cand  <= '0;
      j     <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (restart) begin
        err_r <= ERR_NONE;
        res   <= WIDTH'(1);
        idx   <= '0;
      end else begin
        if (state != S_ERR && state_n == S_ERR) err_r <= err_n;
        case (state)
          S_NEXT: begin
            cand <= (res < WIDTH'(3)) ? res + WIDTH'(1) : res_p2[WIDTH-1:0];
            j    <= CW'(1);
          end
          S_DIV_WAIT: begin
            if (rem_valid) begin
              if (rem == '0) begin
                cand <= cand_p2[WIDTH-1:0];
                j    <= CW'(1);
              end else j <= j + CW'(1);
            end
          end
          S_COMMIT: begin
            res <= cand;
            idx <= idx + WIDTH'(1);
            if (cache_we) count <= count + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_primegen_cached.sv
// tb/tb_primegen_cached.sv - directed checks of primegen_cached at three parameterisations
module tb_primegen_cached;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        go [3];
  logic        restart [3];
  logic        rst_n [3];
  logic        ready [3];
  logic        error [3];
  logic [1:0]  err_code [3];
  logic [15:0] res_v [3];
  logic [15:0] idx_v [3];
  logic [7:0]  b_res, b_idx, c_res, c_idx;

  int n_cmp = 0;
  int n_bad = 0;

  primegen_cached #(.WIDTH(16), .CACHE_DEPTH(32)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .go(go[0]), .restart(restart[0]),
    .ready(ready[0]), .error(error[0]), .err_code(err_code[0]),
    .res(res_v[0]), .idx(idx_v[0]));

  primegen_cached #(.WIDTH(8), .CACHE_DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .go(go[1]), .restart(restart[1]),
    .ready(ready[1]), .error(error[1]), .err_code(err_code[1]),
    .res(b_res), .idx(b_idx));

  primegen_cached #(.WIDTH(8), .CACHE_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n[2]), .go(go[2]), .restart(restart[2]),
    .ready(ready[2]), .error(error[2]), .err_code(err_code[2]),
    .res(c_res), .idx(c_idx));

  assign res_v[1] = {8'd0, b_res};
  assign idx_v[1] = {8'd0, b_idx};
  assign res_v[2] = {8'd0, c_res};
  assign idx_v[2] = {8'd0, c_idx};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_prime(input int r);
    int c;
    bit comp;
    if (r < 3) return r + 1;
    c = r + 2;
    forever begin
      comp = 1'b0;
      for (int d = 3; d * d <= c; d += 2) if (c % d == 0) comp = 1'b1;
      if (!comp) return c;
      c += 2;
    end
  endfunction

  task automatic wait_ready(input int s);
    for (int k = 0; k < 3000 && !ready[s]; k++) @(negedge clk);
    chk("ready_timeout", 32'(ready[s]), 1);
  endtask

  task automatic step(input int s);
    go[s] = 1'b1;
    @(negedge clk);
    go[s] = 1'b0;
    wait_ready(s);
  endtask

  task automatic do_reset(input int s);
    rst_n[s] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[s] = 1'b1;
  endtask

  int m;
  int p16 [12] = '{1, 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};

  initial begin
    for (int s = 0; s < 3; s++) begin
      go[s] = 1'b0; restart[s] = 1'b0; rst_n[s] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;

    chk("rst_res", 32'(res_v[0]), 1);
    chk("rst_idx", 32'(idx_v[0]), 0);
    chk("rst_ready", 32'(ready[0]), 1);
    chk("rst_error", 32'(error[0]), 0);
    chk("rst_err_code", 32'(err_code[0]), 0);

    for (int i = 1; i < 12; i++) begin
      step(0);
      chk("w16_res", 32'(res_v[0]), 32'(p16[i]));
      chk("w16_idx", 32'(idx_v[0]), 32'(i));
    end

    m = 1;
    for (int i = 1; i <= 60 && m != 251; i++) begin
      step(1);
      m = next_prime(m);
      chk("w8_res", 32'(res_v[1]), 32'(m));
      chk("w8_idx", 32'(idx_v[1]), 32'(i));
    end
    chk("w8_last_idx", 32'(idx_v[1]), 54);
    step(1);
    chk("ovf_error", 32'(error[1]), 1);
    chk("ovf_code", 32'(err_code[1]), 1);
    chk("ovf_res", 32'(res_v[1]), 251);
    chk("ovf_idx", 32'(idx_v[1]), 54);
    step(1);
    chk("err_go_res", 32'(res_v[1]), 251);
    chk("err_go_error", 32'(error[1]), 1);
    restart[1] = 1'b1;
    @(negedge clk);
    restart[1] = 1'b0;
    chk("err_restart_error", 32'(error[1]), 0);
    chk("err_restart_code", 32'(err_code[1]), 0);
    chk("err_restart_res", 32'(res_v[1]), 1);

    m = 1;
    for (int i = 1; i <= 30 && m != 79; i++) begin
      step(2);
      m = next_prime(m);
      chk("d4_res", 32'(res_v[2]), 32'(m));
    end
    chk("d4_last_idx", 32'(idx_v[2]), 22);
    step(2);
    chk("cache_error", 32'(error[2]), 1);
    chk("cache_code", 32'(err_code[2]), 2);
    chk("cache_res", 32'(res_v[2]), 79);

    go[0] = 1'b1;
    @(negedge clk);
    wait_ready(0);
    go[0] = 1'b0;
    @(negedge clk);
    chk("held_go_res", 32'(res_v[0]), 37);
    chk("held_go_idx", 32'(idx_v[0]), 12);

    do_reset(0);
    for (int i = 0; i < 6; i++) step(0);
    chk("pre_restart_res", 32'(res_v[0]), 13);
    restart[0] = 1'b1;
    go[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    go[0] = 1'b0;
    chk("restart_res", 32'(res_v[0]), 1);
    chk("restart_idx", 32'(idx_v[0]), 0);
    chk("restart_ready", 32'(ready[0]), 1);
    @(negedge clk);
    chk("restart_go_ignored", 32'(res_v[0]), 1);
    for (int i = 1; i <= 3; i++) begin
      step(0);
      chk("replay_res", 32'(res_v[0]), 32'(p16[i]));
    end
    chk("replay_count", 32'(u_a.count), 6);

    step(0);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_div_busy", 32'(ready[0]), 0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("abort_ready", 32'(ready[0]), 1);
    chk("abort_res", 32'(res_v[0]), 1);
    chk("abort_err_code", 32'(err_code[0]), 0);
    chk("abort_count", 32'(u_a.count), 0);
    step(0);
    chk("abort_next_res", 32'(res_v[0]), 2);
    chk("abort_next_count", 32'(u_a.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
